// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with one shared column-sequenced debounce and valid/ack key reporting
// Ports: CLK, RST_N (async active-low); ROW raw row inputs; COL one-hot column drive;
//   KEY_CODE {row,col} / KEY_VALID / KEY_ACK key handshake; OVERRUN sticky drop flag, OVR_CLR clears it;
//   BUSY high whenever the FSM is not scanning.
// Build option: define KEYPAD_AUTOREPEAT_EN to re-report a held key every REPEAT_TICKS ticks.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 2500,
    parameter int DB_TICKS     = 4,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       OVERRUN,
    input  logic       OVR_CLR,
    output logic       BUSY
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} state_t;
    state_t state, state_n;
    logic [3:0] row_m, row_s;
    logic [PW-1:0] pre;
    logic tick, row_bit, valid_n, ovr_n;
    logic [1:0] key_row, key_row_n, key_col, key_col_n;
    logic [3:0] db_cnt, db_n, rel_cnt, rel_n, col_n, col_rot, code_n;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_TICKS + 1);
    logic [HW-1:0] hold_cnt, hold_n;
`else
    localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif
    assign tick    = pre == PW'(SCAN_DIV - 1);
    assign row_bit = row_s[key_row];
    assign col_rot = {COL[2:0], COL[3]};
    assign BUSY    = state != SCAN;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_m     <= '0;
            row_s     <= '0;
            pre       <= '0;
            state     <= SCAN;
            COL       <= 4'b0001;
            key_row   <= '0;
            key_col   <= '0;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            KEY_CODE  <= '0;
            KEY_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            row_m     <= ROW;
            row_s     <= row_m;
            pre       <= tick ? '0 : pre + PW'(1);
            state     <= state_n;
            COL       <= col_n;
            key_row   <= key_row_n;
            key_col   <= key_col_n;
            db_cnt    <= db_n;
            rel_cnt   <= rel_n;
            KEY_CODE  <= code_n;
            KEY_VALID <= valid_n;
            OVERRUN   <= ovr_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_cnt  <= hold_n;
`endif
        end
    end
    always_comb begin
        state_n   = state;
        col_n     = COL;
        key_row_n = key_row;
        key_col_n = key_col;
        db_n      = db_cnt;
        rel_n     = rel_cnt;
        code_n    = KEY_CODE;
        valid_n   = KEY_VALID & ~KEY_ACK;
        ovr_n     = OVERRUN & ~OVR_CLR;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_n    = hold_cnt;
`endif
        case (state)
            SCAN: if (tick) begin
                if (row_s != 4'd0) begin
                    // lowest row wins when several rows close on the same column
                    key_row_n = row_s[0] ? 2'd0 : row_s[1] ? 2'd1 : row_s[2] ? 2'd2 : 2'd3;
                    key_col_n = COL[0] ? 2'd0 : COL[1] ? 2'd1 : COL[2] ? 2'd2 : 2'd3;
                    db_n      = 4'd1;
                    state_n   = (DB_TICKS == 1) ? REPORT : DEBOUNCE;
                end else begin
                    col_n = col_rot;
                end
            end
            DEBOUNCE: if (tick) begin
                if (row_bit) begin
                    db_n = db_cnt + 4'd1;
                    if (db_n == 4'(DB_TICKS)) state_n = REPORT;
                end else begin
                    state_n = SCAN;
                    col_n   = col_rot;
                end
            end
            REPORT: begin
                // an ack in this same cycle frees the slot, so the new key replaces the old one
                if (!KEY_VALID || KEY_ACK) begin
                    code_n  = {key_row, key_col};
                    valid_n = 1'b1;
                end else begin
                    ovr_n = 1'b1;
                end
                rel_n   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                hold_n  = '0;
`endif
                state_n = RELEASE;
            end
            default: if (tick) begin
                if (!row_bit) begin
                    rel_n = rel_cnt + 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    hold_n = '0;
`endif
                    if (rel_n == 4'(DB_TICKS)) begin
                        state_n = SCAN;
                        col_n   = col_rot;
                    end
                end else begin
                    rel_n = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    hold_n = hold_cnt + HW'(1);
                    if (hold_n == HW'(REPEAT_TICKS)) state_n = REPORT;
`endif
                end
            end
        endcase
    end
endmodule
